// File: rtl/srio_xfer_seq.sv
// Doorbell + NWRITE transfer sequencer for an SRIO logical layer.
// Moore FSM: every output is registered and decoded from the next state.
module srio_xfer_seq #(
  parameter int unsigned GAP_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       log_clk,
  input  logic       log_rst_n,
  input  logic       start_in,
  input  logic [7:0] xfer_count_in,
  input  logic       abort_in,
  input  logic       link_initialized_in,
  input  logic       rapidIO_ready_in,
  input  logic       nwr_ready_in,
  input  logic       nwr_done_ack_in,
  output logic       self_check_o,
  output logic       nwr_req_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [1:0] err_code_o,
  output logic [7:0] rounds_done_o
);

  typedef enum logic [2:0] {
    StIdle, StDbReq, StDbWait, StGap, StNwrReq, StNwrWait, StDone, StErr
  } state_e;

  localparam logic [7:0]  GapLast  = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        ret_nwr_q, ret_nwr_d;  // GAP exit target: 1 = NWR_REQ, 0 = DB_REQ
  logic [7:0]  gap_q, gap_d;
  logic [15:0] wdog_q, wdog_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  rounds_d;
  logic        error_d;
  logic [1:0]  code_d;

  always_comb begin
    state_d   = state_q;
    ret_nwr_d = ret_nwr_q;
    gap_d     = gap_q;
    wdog_d    = wdog_q;
    target_d  = target_q;
    rounds_d  = rounds_done_o;
    error_d   = error_o;
    code_d    = err_code_o;

    unique case (state_q)
      StIdle: begin
        if (start_in && link_initialized_in) begin
          target_d = xfer_count_in;
          rounds_d = 8'd0;
          error_d  = 1'b0;
          code_d   = 2'b00;
          state_d  = (xfer_count_in == 8'd0) ? StDone : StDbReq;
        end
      end
      StDbReq: begin
        wdog_d  = 16'd0;
        state_d = StDbWait;
      end
      StDbWait: begin
        if (rapidIO_ready_in && nwr_ready_in) begin
          gap_d     = 8'd0;
          ret_nwr_d = 1'b1;
          state_d   = StGap;
        end else if (wdog_q == WdogLast) begin
          error_d = 1'b1;
          code_d  = 2'b01;
          state_d = StErr;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = ret_nwr_q ? StNwrReq : StDbReq;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      StNwrReq: begin
        wdog_d  = 16'd0;
        state_d = StNwrWait;
      end
      StNwrWait: begin
        if (nwr_done_ack_in && rapidIO_ready_in) begin
          rounds_d = rounds_done_o + 8'd1;
          if (rounds_done_o + 8'd1 == target_q) begin
            state_d = StDone;
          end else begin
            gap_d     = 8'd0;
            ret_nwr_d = 1'b0;
            state_d   = StGap;
          end
        end else if (wdog_q == WdogLast) begin
          error_d = 1'b1;
          code_d  = 2'b10;
          state_d = StErr;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Link loss overrides any same-cycle completion or timeout.
    if (!link_initialized_in &&
        (state_q inside {StDbReq, StDbWait, StGap, StNwrReq, StNwrWait})) begin
      rounds_d = rounds_done_o;
      error_d  = 1'b1;
      code_d   = 2'b11;
      state_d  = StErr;
    end

    // Abort wins over everything and leaves status untouched.
    if (abort_in && (state_q != StIdle)) begin
      rounds_d = rounds_done_o;
      error_d  = error_o;
      code_d   = err_code_o;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge log_clk) begin
    if (!log_rst_n) begin
      state_q       <= StIdle;
      ret_nwr_q     <= 1'b0;
      gap_q         <= 8'd0;
      wdog_q        <= 16'd0;
      target_q      <= 8'd0;
      self_check_o  <= 1'b0;
      nwr_req_o     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      err_code_o    <= 2'b00;
      rounds_done_o <= 8'd0;
    end else begin
      state_q       <= state_d;
      ret_nwr_q     <= ret_nwr_d;
      gap_q         <= gap_d;
      wdog_q        <= wdog_d;
      target_q      <= target_d;
      self_check_o  <= (state_d == StDbReq);
      nwr_req_o     <= (state_d == StNwrReq);
      busy_o        <= (state_d != StIdle);
      done_o        <= (state_d == StDone);
      error_o       <= error_d;
      err_code_o    <= code_d;
      rounds_done_o <= rounds_d;
    end
  end

endmodule

// File: tb/tb_srio_xfer_seq.sv
// Scoreboard bench for srio_xfer_seq: stimulus queues expected output events,
// a negedge monitor pops and compares each pulse / error entry.
module tb_srio_xfer_seq;

  logic       log_clk = 1'b0;
  logic       log_rst_n;
  logic       start_in;
  logic [7:0] xfer_count_in;
  logic       abort_in;
  logic       link_initialized_in;
  logic       rapidIO_ready_in;
  logic       nwr_ready_in;
  logic       nwr_done_ack_in;
  logic       self_check_o;
  logic       nwr_req_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic [1:0] err_code_o;
  logic [7:0] rounds_done_o;

  always #5 log_clk = ~log_clk;

  srio_xfer_seq #(
    .GAP_CYCLES    (3),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .log_clk            (log_clk),
    .log_rst_n          (log_rst_n),
    .start_in           (start_in),
    .xfer_count_in      (xfer_count_in),
    .abort_in           (abort_in),
    .link_initialized_in(link_initialized_in),
    .rapidIO_ready_in   (rapidIO_ready_in),
    .nwr_ready_in       (nwr_ready_in),
    .nwr_done_ack_in    (nwr_done_ack_in),
    .self_check_o       (self_check_o),
    .nwr_req_o          (nwr_req_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .error_o            (error_o),
    .err_code_o         (err_code_o),
    .rounds_done_o      (rounds_done_o)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] rounds;
    logic [1:0] code;
  } ev_t;

  localparam logic [1:0] KDb = 2'd0, KNwr = 2'd1, KDone = 2'd2, KErr = 2'd3;

  ev_t exp_q[$];
  ev_t mon_got, mon_exp;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_req = 0;
  bit  have_last = 0;
  bit  db_en = 1'b1;
  bit  nwr_en = 1'b1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input logic [1:0] k, input int r, input logic [1:0] c);
    ev_t e;
    e.kind   = k;
    e.rounds = 8'(r);
    e.code   = c;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge log_clk);
  endtask

  task automatic pulse_start(input logic [7:0] cnt);
    start_in      = 1'b1;
    xfer_count_in = cnt;
    @(negedge log_clk);
    start_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge log_clk);
      n++;
    end
    if (busy_o) begin
      checks++;
      failures++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic wait_req(input bit nwr, input int nth, input int budget);
    int n = 0;
    int seen = 0;
    while (seen < nth && n < budget) begin
      @(negedge log_clk);
      n++;
      if (nwr ? nwr_req_o : self_check_o) seen++;
    end
    if (seen < nth) begin
      checks++;
      failures++;
      $display("FAIL wait_req: saw %0d pulses, expected %0d", seen, nth);
    end
  endtask

  // Doorbell responder: ready drops on request, returns 10 cycles later.
  initial forever begin
    @(negedge log_clk);
    if (self_check_o) begin
      rapidIO_ready_in = 1'b0;
      nwr_ready_in     = 1'b0;
      if (db_en) begin
        repeat (10) @(negedge log_clk);
        rapidIO_ready_in = 1'b1;
        nwr_ready_in     = 1'b1;
      end
    end
  end

  // NWRITE responder: ack drops on request, returns 10 cycles later if enabled.
  initial forever begin
    @(negedge log_clk);
    if (nwr_req_o) begin
      nwr_done_ack_in = 1'b0;
      if (nwr_en) begin
        repeat (10) @(negedge log_clk);
        nwr_done_ack_in = 1'b1;
      end
    end
  end

  // Monitor: every request/done pulse and ERR entry must match the queue head.
  initial forever begin
    @(negedge log_clk);
    cyc++;
    if (!busy_o) have_last = 0;
    if (self_check_o || nwr_req_o || done_o || (error_o && busy_o)) begin
      mon_got.kind   = self_check_o ? KDb : nwr_req_o ? KNwr : done_o ? KDone : KErr;
      mon_got.rounds = rounds_done_o;
      mon_got.code   = err_code_o;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got kind %0d, expected no event", mon_got.kind);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event_kind", int'(mon_got.kind), int'(mon_exp.kind));
        check("event_rounds", int'(mon_got.rounds), int'(mon_exp.rounds));
        check("event_code", int'(mon_got.code), int'(mon_exp.code));
      end
      if (self_check_o || nwr_req_o) begin
        // 10-cycle responder + 3 gap cycles puts requests exactly 14 cycles apart.
        if (have_last) check("req_spacing", cyc - last_req, 14);
        have_last = 1;
        last_req  = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    log_rst_n           = 1'b0;
    start_in            = 1'b1;
    xfer_count_in       = 8'd5;
    abort_in            = 1'b0;
    link_initialized_in = 1'b1;
    rapidIO_ready_in    = 1'b0;
    nwr_ready_in        = 1'b0;
    nwr_done_ack_in     = 1'b0;
    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_self_check", self_check_o, 0);
    check("rst_nwr_req", nwr_req_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_code", err_code_o, 0);
    check("rst_rounds", rounds_done_o, 0);
    start_in  = 1'b0;
    log_rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", busy_o, 0);

    // Nominal five rounds, with an ignored start while busy.
    for (int r = 0; r < 5; r++) begin
      push(KDb, r, 2'b00);
      push(KNwr, r, 2'b00);
    end
    push(KDone, 5, 2'b00);
    pulse_start(8'd5);
    check("start_latency", self_check_o, 1);
    check("nominal_busy", busy_o, 1);
    tick(3);
    pulse_start(8'd1);
    wait_idle("nominal_idle", 2000);
    check("nominal_rounds", rounds_done_o, 5);
    check("nominal_error", error_o, 0);
    tick(5);

    // Zero count completes with no requests.
    push(KDone, 0, 2'b00);
    pulse_start(8'd0);
    check("zero_done", done_o, 1);
    tick(1);
    check("zero_idle", busy_o, 0);
    tick(3);

    // Start with link down is ignored.
    link_initialized_in = 1'b0;
    pulse_start(8'd3);
    check("linkdown_ignored", busy_o, 0);
    link_initialized_in = 1'b1;
    tick(3);

    // NWRITE timeout at 64 cycles.
    nwr_en = 1'b0;
    push(KDb, 0, 2'b00);
    push(KNwr, 0, 2'b00);
    push(KErr, 0, 2'b10);
    pulse_start(8'd2);
    wait_req(1'b1, 1, 100);
    n = 0;
    while (n < 200) begin
      @(negedge log_clk);
      if (error_o) break;
      n++;
    end
    check("timeout_cycles", n, 64);
    check("timeout_code", err_code_o, 2);
    check("timeout_err_busy", busy_o, 1);
    tick(1);
    check("timeout_idle", busy_o, 0);
    check("timeout_sticky", error_o, 1);
    nwr_en = 1'b1;
    tick(20);

    // Link loss during round 3, then a fresh start clears the error.
    push(KDb, 0, 2'b00);
    push(KNwr, 0, 2'b00);
    push(KDb, 1, 2'b00);
    push(KNwr, 1, 2'b00);
    push(KDb, 2, 2'b00);
    push(KErr, 2, 2'b11);
    pulse_start(8'd5);
    wait_req(1'b0, 2, 200);
    link_initialized_in = 1'b0;
    tick(1);
    check("linkloss_code", err_code_o, 3);
    check("linkloss_error", error_o, 1);
    check("linkloss_rounds", rounds_done_o, 2);
    tick(1);
    check("linkloss_idle", busy_o, 0);
    link_initialized_in = 1'b1;
    tick(20);
    push(KDb, 0, 2'b00);
    push(KNwr, 0, 2'b00);
    push(KDone, 1, 2'b00);
    pulse_start(8'd1);
    check("restart_error_clr", error_o, 0);
    check("restart_code_clr", err_code_o, 0);
    wait_idle("restart_idle", 500);
    check("restart_rounds", rounds_done_o, 1);
    tick(20);

    // Abort in DB_WAIT.
    push(KDb, 0, 2'b00);
    pulse_start(8'd3);
    tick(2);
    abort_in = 1'b1;
    tick(1);
    abort_in = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_error", error_o, 0);
    tick(20);

    // Reset in NWR_WAIT of round 2 clears everything.
    push(KDb, 0, 2'b00);
    push(KNwr, 0, 2'b00);
    push(KDb, 1, 2'b00);
    push(KNwr, 1, 2'b00);
    pulse_start(8'd3);
    wait_req(1'b1, 2, 200);
    tick(1);
    log_rst_n = 1'b0;
    tick(1);
    check("midrst_busy", busy_o, 0);
    check("midrst_rounds", rounds_done_o, 0);
    check("midrst_nwr_req", nwr_req_o, 0);
    check("midrst_error", error_o, 0);
    log_rst_n = 1'b1;
    tick(20);

    // Abort together with the final ack: no done, rounds not incremented.
    nwr_en = 1'b0;
    push(KDb, 0, 2'b00);
    push(KNwr, 0, 2'b00);
    pulse_start(8'd1);
    wait_req(1'b1, 1, 200);
    tick(1);
    abort_in        = 1'b1;
    nwr_done_ack_in = 1'b1;
    tick(1);
    abort_in        = 1'b0;
    nwr_done_ack_in = 1'b0;
    check("abort_ack_busy", busy_o, 0);
    check("abort_ack_done", done_o, 0);
    check("abort_ack_rounds", rounds_done_o, 0);
    nwr_en = 1'b1;
    tick(20);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srio_xfer_seq.md
SRIO_XFER_SEQ -- requirements
Module: srio_xfer_seq

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 3: idle cycles between handshake phases, range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit per wait state, range 1..65535.
REQ-003 SHALL have port log_clk  in  1  sole clock; every flop updates on its rising edge.
REQ-004 SHALL have port log_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_in  in  1  one-cycle pulse that launches a transfer sequence.
REQ-006 SHALL have port xfer_count_in  in  8  number of doorbell+NWRITE rounds, sampled with start_in.
REQ-007 SHALL have port abort_in  in  1  level; cancels any active sequence.
REQ-008 SHALL have port link_initialized_in  in  1  SRIO link-up status.
REQ-009 SHALL have port rapidIO_ready_in  in  1  doorbell round trip complete, from the requester.
REQ-010 SHALL have port nwr_ready_in  in  1  NWRITE path able to accept a request.
REQ-011 SHALL have port nwr_done_ack_in  in  1  NWRITE response received.
REQ-012 SHALL have port self_check_o  out  1  one-cycle doorbell request pulse.
REQ-013 SHALL have port nwr_req_o  out  1  one-cycle NWRITE request pulse.
REQ-014 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-015 SHALL have port done_o  out  1  one-cycle pulse when all rounds finish.
REQ-016 SHALL have port error_o  out  1  sticky error flag.
REQ-017 SHALL have port err_code_o  out  2  01 doorbell timeout, 10 NWRITE timeout, 11 link loss, 00 none.
REQ-018 SHALL have port rounds_done_o  out  8  count of rounds completed in the current or last sequence.

Function
REQ-019 SHALL register all outputs and decode them from state only (Moore).
REQ-020 SHALL implement states IDLE, DB_REQ, DB_WAIT, GAP, NWR_REQ, NWR_WAIT, DONE, ERR.
REQ-021 IDLE: start_in=1, link_initialized_in=1 and xfer_count_in!=0 -> DB_REQ; latch target, clear rounds_done_o, error_o and err_code_o.
REQ-022 IDLE: start_in with xfer_count_in=0 -> DONE directly, no requests issued; with link down -> ignored.
REQ-023 DB_REQ: self_check_o=1 for exactly that cycle -> DB_WAIT.
REQ-024 DB_WAIT: rapidIO_ready_in=1 and nwr_ready_in=1 in the same cycle -> GAP, return target NWR_REQ.
REQ-025 GAP: hold GAP_CYCLES cycles via 8-bit counter, then -> return target.
REQ-026 NWR_REQ: nwr_req_o=1 for exactly that cycle -> NWR_WAIT.
REQ-027 NWR_WAIT: nwr_done_ack_in=1 and rapidIO_ready_in=1 -> increment rounds_done_o; if new value equals target -> DONE, else -> GAP with return target DB_REQ.
REQ-028 DONE: done_o=1 for one cycle -> IDLE.
REQ-029 SHALL clear a 16-bit watchdog on entry to DB_WAIT/NWR_WAIT; reaching TIMEOUT_CYCLES without the exit condition -> ERR with code 01/10 respectively.
REQ-030 SHALL go to ERR with code 11 when link_initialized_in=0 in any state other than IDLE, DONE, ERR; link loss takes priority over timeout in the same cycle.
REQ-031 ERR: error_o=1, busy_o=1 for one cycle -> IDLE; error_o and err_code_o hold until the next accepted start_in.
REQ-032 abort_in=1 in any non-IDLE state -> IDLE next cycle, no done_o, no error, rounds_done_o retained; abort has priority over all other transitions.
REQ-033 start_in while busy_o=1 SHALL be ignored.
REQ-034 Minimum latency: start_in at edge k -> self_check_o high in cycle k+1.

Reset
REQ-035 log_rst_n=0 at a rising edge SHALL force IDLE, counters to 0, all outputs to 0, including mid-sequence; no pulse output is emitted on reset release.

Verification
REQ-036 Nominal: xfer_count_in=5, ready/ack responders after 10 cycles -> 5 self_check_o and 5 nwr_req_o pulses in alternation, each phase separated by >=3 idle cycles, then done_o once, rounds_done_o=5.
REQ-037 Zero count: start_in with xfer_count_in=0 -> done_o within 2 cycles, no request pulses.
REQ-038 Timeout: TIMEOUT_CYCLES=64, nwr_done_ack_in never asserted -> error_o=1, err_code_o=10 exactly 64 cycles after NWR_WAIT entry, then busy_o=0.
REQ-039 Link loss: drop link_initialized_in during round 3 -> err_code_o=11, rounds_done_o=2; next start_in clears error.
REQ-040 Abort/reset mid-sequence: abort_in in DB_WAIT -> busy_o=0 next cycle, no done_o; log_rst_n=0 in NWR_WAIT -> all outputs 0 next cycle.
REQ-041 Same-cycle priority: abort_in together with nwr_done_ack_in on the final round -> IDLE, no done_o.
